// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter feeding the 32x32 register file write port.
// Merges ALU (src0) and long-latency (src1) results through one registered
// stage, and tracks pending writes in a 32-bit busy scoreboard.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   src0_valid/ready/rd/data   ALU result handshake
//   src1_valid/ready/rd/data   long-latency unit result handshake
//   iss_valid/ready/rd         issue-stage destination claim
//   we, waddr, wdata           registered register-file write port
//   busy                       scoreboard, bit n = write to xn outstanding
//
// Optional feature: define WB_STARVE_GUARD_EN to add a src1 starvation
// guard; src1 wins once it has waited STARVE_LIMIT consecutive cycles.
module wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [4:0]  src0_rd,
    input  logic [31:0] src0_data,
    input  logic        src1_valid,
    output logic        src1_ready,
    input  logic [4:0]  src1_rd,
    input  logic [31:0] src1_data,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rd,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic [31:0] busy
);

    logic        sel0;
    logic        sel1;
    logic        xfer;
    logic [4:0]  rd_in;
    logic [31:0] data_in;
    logic [31:0] busy_next;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       starve;

    assign starve     = (starve_cnt >= LIMIT);
    assign src0_ready = !starve;
    assign src1_ready = starve || !src0_valid;

    // Counts consecutive cycles src1 is held off; any src1 transfer
    // or a dropped src1_valid restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!src1_valid || src1_ready) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign src0_ready = 1'b1;
    assign src1_ready = !src0_valid;
`endif

    // The ready equations never grant both sources while both are valid,
    // so the src1 term is masked by sel0 only for robustness.
    always_comb begin
        sel0    = src0_valid && src0_ready;
        sel1    = src1_valid && src1_ready && !sel0;
        xfer    = sel0 || sel1;
        rd_in   = sel0 ? src0_rd : src1_rd;
        data_in = sel0 ? src0_data : src1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else begin
            // x0 results are consumed but never written.
            we <= xfer && (rd_in != 5'd0);
            if (xfer) begin
                waddr <= rd_in;
                wdata <= data_in;
            end
        end
    end

    assign iss_ready = !busy[iss_rd] || (iss_rd == 5'd0);

    // Clear is applied before set so a same-edge claim keeps the bit.
    always_comb begin
        busy_next = busy;
        if (we) begin
            busy_next[waddr] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != 5'd0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_wb_arbiter;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        src0_valid = 1'b0;
    logic        src0_ready;
    logic [4:0]  src0_rd = 5'd0;
    logic [31:0] src0_data = 32'd0;
    logic        src1_valid = 1'b0;
    logic        src1_ready;
    logic [4:0]  src1_rd = 5'd0;
    logic [31:0] src1_data = 32'd0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [4:0]  iss_rd = 5'd0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;

    int total = 0;
    int bad = 0;

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .src0_valid(src0_valid),
        .src0_ready(src0_ready),
        .src0_rd(src0_rd),
        .src0_data(src0_data),
        .src1_valid(src1_valid),
        .src1_ready(src1_ready),
        .src1_rd(src1_rd),
        .src1_data(src1_data),
        .iss_valid(iss_valid),
        .iss_ready(iss_ready),
        .iss_rd(iss_rd),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, with a src0 result presented that must be ignored
        #2 rst_n = 1'b0;
        src0_valid = 1'b1;
        src0_rd = 5'd1;
        src0_data = 32'h1111_1111;
        #1;
        chk("rst_src0_ready", 32'(src0_ready), 32'd1);
        chk("rst_src1_ready", 32'(src1_ready), 32'd0);
        tick();
        tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", busy, 32'd0);
        src0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_we", 32'(we), 32'd0);

        // Plain src0 write rd5
        src0_valid = 1'b1;
        src0_rd = 5'd5;
        src0_data = 32'hDEAD_BEEF;
        #1;
        chk("s0_src0_ready", 32'(src0_ready), 32'd1);
        chk("s0_src1_ready", 32'(src1_ready), 32'd0);
        tick();
        src0_valid = 1'b0;
        chk("s0_we", 32'(we), 32'd1);
        chk("s0_waddr", 32'(waddr), 32'd5);
        chk("s0_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        chk("s0_we_drop", 32'(we), 32'd0);
        chk("s0_waddr_hold", 32'(waddr), 32'd5);
        chk("s0_wdata_hold", wdata, 32'hDEAD_BEEF);

        // Claim x7, then src1 writes x7
        iss_valid = 1'b1;
        iss_rd = 5'd7;
        #1;
        chk("claim7_ready", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("claim7_busy", busy, 32'h0000_0080);
        chk("claim7_ready_busy", 32'(iss_ready), 32'd0);
        src1_valid = 1'b1;
        src1_rd = 5'd7;
        src1_data = 32'h0000_1234;
        #1;
        chk("s1_ready_idle", 32'(src1_ready), 32'd1);
        tick();
        src1_valid = 1'b0;
        chk("s1_we", 32'(we), 32'd1);
        chk("s1_waddr", 32'(waddr), 32'd7);
        chk("s1_wdata", wdata, 32'h0000_1234);
        chk("s1_busy_still", busy, 32'h0000_0080);
        tick();
        chk("s1_busy_clear", busy, 32'd0);
        chk("s1_we_drop", 32'(we), 32'd0);
        chk("s1_iss_ready", 32'(iss_ready), 32'd1);

        // Contention: both sources valid for six cycles
        src0_valid = 1'b1;
        src1_valid = 1'b1;
        src0_rd = 5'd3;
        src1_rd = 5'd4;
        for (int i = 0; i < 6; i++) begin
            logic s1win;
            s1win = GUARD && (i == 4);
            src0_data = 32'hA000_0000 + 32'(i);
            src1_data = 32'hB000_0000 + 32'(i);
            #1;
            chk($sformatf("arb_src0_ready_%0d", i), 32'(src0_ready),
                32'(!s1win));
            chk($sformatf("arb_src1_ready_%0d", i), 32'(src1_ready),
                32'(s1win));
            tick();
            chk($sformatf("arb_we_%0d", i), 32'(we), 32'd1);
            chk($sformatf("arb_waddr_%0d", i), 32'(waddr),
                s1win ? 32'd4 : 32'd3);
            chk($sformatf("arb_wdata_%0d", i), wdata,
                (s1win ? 32'hB000_0000 : 32'hA000_0000) + 32'(i));
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        tick();
        chk("arb_idle_we", 32'(we), 32'd0);

        // Write to x0 is consumed but not written
        src0_valid = 1'b1;
        src0_rd = 5'd0;
        src0_data = 32'hFFFF_FFFF;
        tick();
        src0_valid = 1'b0;
        chk("x0_we", 32'(we), 32'd0);
        chk("x0_waddr", 32'(waddr), 32'd0);
        chk("x0_wdata", wdata, 32'hFFFF_FFFF);
        chk("x0_busy", busy, 32'd0);
        iss_valid = 1'b1;
        iss_rd = 5'd0;
        #1;
        chk("x0_iss_ready", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
        chk("x0_claim_busy", busy, 32'd0);

        // Same-edge clear and claim of x9
        src0_valid = 1'b1;
        src0_rd = 5'd9;
        src0_data = 32'h0000_0099;
        tick();
        src0_valid = 1'b0;
        chk("x9_we", 32'(we), 32'd1);
        chk("x9_waddr", 32'(waddr), 32'd9);
        iss_valid = 1'b1;
        iss_rd = 5'd9;
        #1;
        chk("x9_iss_ready", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
        chk("x9_set_wins", busy, 32'h0000_0200);
        chk("x9_we_drop", 32'(we), 32'd0);

        // Async reset while busy=0x300 and we=1
        iss_valid = 1'b1;
        iss_rd = 5'd8;
        src0_valid = 1'b1;
        src0_rd = 5'd8;
        src0_data = 32'h0000_0088;
        tick();
        iss_valid = 1'b0;
        src0_valid = 1'b0;
        chk("pre_arst_busy", busy, 32'h0000_0300);
        chk("pre_arst_we", 32'(we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(we), 32'd0);
        chk("arst_busy", busy, 32'd0);
        chk("arst_waddr", 32'(waddr), 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_rel_we", 32'(we), 32'd0);
        chk("arst_rel_busy", busy, 32'd0);
        iss_rd = 5'd8;
        #1;
        chk("arst_iss_ready", 32'(iss_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback stage directly upstream of the 32x32 register file. Accepts results from two execution sources (single-cycle ALU, multi-cycle long-latency unit) over valid/ready handshakes, arbitrates them onto the register file's single write port through one registered output stage, and keeps a 32-bit pending-write scoreboard so issue logic can stall on registers with outstanding writes.

## Interface

Parameters:
- STARVE_LIMIT, default 4: with the starvation guard compiled in, the number of consecutive cycles src1 waits before it takes priority. Legal range 1-15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- src0_valid  in  1  ALU result valid
- src0_ready  out  1  ALU result accepted this cycle
- src0_rd  in  5  ALU destination register
- src0_data  in  32  ALU result
- src1_valid  in  1  long-latency unit result valid
- src1_ready  out  1  long-latency result accepted this cycle
- src1_rd  in  5  long-latency destination register
- src1_data  in  32  long-latency result
- iss_valid  in  1  issue stage claims a destination register
- iss_ready  out  1  claim accepted; combinational, equals !busy[iss_rd] || iss_rd==0
- iss_rd  in  5  claimed destination register
- we  out  1  register file write enable, registered
- waddr  out  5  register file write address, registered
- wdata  out  32  register file write data, registered
- busy  out  32  scoreboard, bit n set = write to register n outstanding

## Operation

- Transfer on srcK happens when srcK_valid && srcK_ready at a rising edge. At most one transfer per cycle.
- Default arbitration, fixed priority: src0_ready = 1; src1_ready = !src0_valid. Ready signals are combinational from valid inputs and the starvation state only.
- Accepted transfer loads waddr/wdata from the winning source at that edge; we = 1 for the following cycle only if rd != 0. A transfer with rd == 0 is accepted and discarded (we = 0, waddr/wdata still load).
- No transfer in a cycle: we = 0 next cycle; waddr/wdata hold.
- Scoreboard set: iss_valid && iss_ready && iss_rd != 0 sets busy[iss_rd] at the edge.
- Scoreboard clear: busy[waddr] clears at the edge ending any cycle with we = 1, the same edge at which the register file commits the write. Readers therefore never see busy = 0 with stale file contents.
- Set and clear of the same register at the same edge: set wins, busy stays 1.
- busy[0] is constant 0.
- Source results for a register whose busy bit is clear are legal. They are written and leave the scoreboard unchanged. The issue side guarantees one outstanding write per register.

## Timing

- Reset (rst_n low, asynchronous): we = 0, waddr = 0, wdata = 0, busy = 0, starvation counter = 0. Ready outputs follow their combinational equations during reset and transfers are ignored.
- Latency: transfer at edge N -> we/waddr/wdata valid in cycle N..N+1 -> register file written at edge N+1 -> busy bit clears at edge N+1.
- Throughput: one write per cycle. Back-to-back src0 transfers yield we = 1 on consecutive cycles.
- Reset deasserted mid-stream: the first transfer is considered at the first rising edge with rst_n high. Writes and claims lost to reset are not replayed.

## Configuration

- WB_STARVE_GUARD_EN defined: a 4-bit counter increments each cycle src1_valid && !src1_ready, saturating at 15. It resets to 0 on a src1 transfer or when src1_valid is low.
  - When counter >= STARVE_LIMIT: src1_ready = 1 and src0_ready = 0 for that cycle, so src1 wins.
- WB_STARVE_GUARD_EN undefined: pure fixed priority. src0_ready is tied to 1, there is no counter, and src1 can starve indefinitely.

## Test plan

- Reset, then src0 write rd=5 data=0xDEADBEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF; we=0 the cycle after.
- iss claim rd=7, then src1 result rd=7 data=0x1234 with src0 idle -> busy[7]=1 from the claim edge; we=1, waddr=7 one cycle after the transfer; busy[7]=0 after the following edge; iss_ready for rd=7 low while busy.
- src0 and src1 both valid, with the guard undefined -> src0 accepted every cycle and src1_ready=0. With the guard defined and STARVE_LIMIT=4 -> src1 accepted on the 5th cycle of waiting and src0_ready=0 that cycle.
- src0 write rd=0 data=0xFFFFFFFF -> transfer accepted, we stays 0, busy[0]=0; a claim with iss_rd=0 has iss_ready=1 and busy unchanged.
- Same-edge clear of busy[9] (we=1, waddr=9) and new claim of rd=9 -> busy[9]=1 afterwards.
- Assert rst_n low mid-cycle while busy=0x0000_0300 and we=1 -> we=0 and busy=0 immediately, without waiting for a clock edge.
